// File: rtl/goe_nport.sv
// Generalised output engine: steers 134-bit UDA packets to one of N_PORTS egress ports or to all
// of them, dropping whole packets on bad port or backpressure, and keeps fwd/drop packet counts.
`timescale 1ns/1ps
module goe_nport #(
    parameter int N_PORTS  = 4,
    parameter int PORT_LSB = 112,
    parameter bit BCAST_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_goe_data_wr,
    input  logic [133:0]           in_goe_data,
    input  logic                   in_goe_valid_wr,
    input  logic                   in_goe_valid,
    input  logic [N_PORTS-1:0]     in_port_alf,
    output logic [N_PORTS-1:0]     pktout_data_wr,
    output logic [N_PORTS*134-1:0] pktout_data,
    output logic [N_PORTS-1:0]     pktout_data_valid_wr,
    output logic [N_PORTS-1:0]     pktout_data_valid,
    output logic [31:0]            fwd_pkt_cnt,
    output logic [31:0]            drop_pkt_cnt
);

    localparam int         W          = 134;
    localparam logic [1:0] HEAD       = 2'b01;
    localparam logic [1:0] TAIL       = 2'b10;
    localparam logic [5:0] BCAST_PORT = 6'h3F;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t               state, state_nxt;
    logic [N_PORTS-1:0]   dst_mask, dst_mask_nxt;
    logic                 drop_flag, drop_flag_nxt;

    logic [1:0]           word_type;
    logic [5:0]           outport;
    logic                 is_head, is_tail;
    logic [N_PORTS-1:0]   head_mask;
    logic                 head_ok;

    logic [N_PORTS-1:0]   wr_nxt, vwr_nxt, vld_nxt;
    logic [N_PORTS*W-1:0] data_nxt;
    logic                 fwd_inc, drop_inc;

    assign word_type = in_goe_data[133:132];
    assign outport   = in_goe_data[PORT_LSB+5:PORT_LSB];
    assign is_head   = in_goe_data_wr && (word_type == HEAD);
    assign is_tail   = in_goe_data_wr && (word_type == TAIL);

    // Head decode: an out-of-range port yields an empty mask, so it is rejected like backpressure.
    always_comb begin
        head_mask = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (outport == 6'(i)) head_mask[i] = 1'b1;
        end
        if (BCAST_EN && (outport == BCAST_PORT)) head_mask = '1;
        head_ok = (head_mask != '0) && ((head_mask & in_port_alf) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (is_head) state_nxt = head_ok ? FWD : DROP;
            FWD:     if (is_head || is_tail) state_nxt = IDLE;
            DROP:    if (is_tail) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A head word seen in FWD closes the current packet; it never opens a new one.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        wr_nxt        = '0;
        dst_mask_nxt  = dst_mask;
        drop_flag_nxt = drop_flag;
        fwd_inc       = 1'b0;
        drop_inc      = 1'b0;
        case (state)
            IDLE: begin
                if (is_head) begin
                    if (head_ok) begin
                        dst_mask_nxt  = head_mask;
                        drop_flag_nxt = 1'b0;
                        wr_nxt        = head_mask;
                    end else begin
                        dst_mask_nxt  = '0;
                        drop_flag_nxt = 1'b1;
                        drop_inc      = 1'b1;
                    end
                end else if (is_tail) begin
                    drop_inc = 1'b1;
                end
            end
            FWD: begin
                if (in_goe_data_wr) begin
                    wr_nxt  = dst_mask;
                    fwd_inc = is_head || is_tail;
                end
            end
            default: ;
        endcase

        for (int i = 0; i < N_PORTS; i++) begin
            data_nxt[i*W +: W] = wr_nxt[i] ? in_goe_data : '0;
        end

        // The valid strobe uses the mask still held from the previous head, even when it
        // coincides with the next head word.
        vwr_nxt = (in_goe_valid_wr && !drop_flag) ? dst_mask : '0;
        vld_nxt = vwr_nxt & {N_PORTS{in_goe_valid}};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            dst_mask             <= '0;
            drop_flag            <= 1'b0;
            pktout_data_wr       <= '0;
            pktout_data          <= '0;
            pktout_data_valid_wr <= '0;
            pktout_data_valid    <= '0;
            fwd_pkt_cnt          <= '0;
            drop_pkt_cnt         <= '0;
        end else begin
            dst_mask             <= dst_mask_nxt;
            drop_flag            <= drop_flag_nxt;
            pktout_data_wr       <= wr_nxt;
            pktout_data          <= data_nxt;
            pktout_data_valid_wr <= vwr_nxt;
            pktout_data_valid    <= vld_nxt;
            if (fwd_inc && (fwd_pkt_cnt != '1))   fwd_pkt_cnt  <= fwd_pkt_cnt + 32'd1;
            if (drop_inc && (drop_pkt_cnt != '1)) drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_goe_nport.sv
// Randomised scoreboard bench for goe_nport: a packet-level reference model queues expected
// per-port words and valid strobes; a negedge monitor pops and compares them cycle-exactly.
`timescale 1ns/1ps
module tb_goe_nport;

    localparam int N        = 4;
    localparam int W        = 134;
    localparam int PORT_LSB = 112;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_goe_data_wr;
    logic [W-1:0]     in_goe_data;
    logic             in_goe_valid_wr;
    logic             in_goe_valid;
    logic [N-1:0]     in_port_alf;
    logic [N-1:0]     pktout_data_wr;
    logic [N*W-1:0]   pktout_data;
    logic [N-1:0]     pktout_data_valid_wr;
    logic [N-1:0]     pktout_data_valid;
    logic [31:0]      fwd_pkt_cnt;
    logic [31:0]      drop_pkt_cnt;

    always #5 clk = ~clk;

    goe_nport #(.N_PORTS(N), .PORT_LSB(PORT_LSB), .BCAST_EN(1'b1)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_goe_data_wr       (in_goe_data_wr),
        .in_goe_data          (in_goe_data),
        .in_goe_valid_wr      (in_goe_valid_wr),
        .in_goe_valid         (in_goe_valid),
        .in_port_alf          (in_port_alf),
        .pktout_data_wr       (pktout_data_wr),
        .pktout_data          (pktout_data),
        .pktout_data_valid_wr (pktout_data_valid_wr),
        .pktout_data_valid    (pktout_data_valid),
        .fwd_pkt_cnt          (fwd_pkt_cnt),
        .drop_pkt_cnt         (drop_pkt_cnt)
    );

    typedef struct { int cyc; logic [W-1:0] data; } wexp_t;
    typedef struct { int cyc; logic flag; } vexp_t;
    typedef enum { OUTSIDE, FORWARDING, DISCARDING } phase_e;

    wexp_t  wq [N][$];
    vexp_t  vq [N][$];
    int     cyc   = 0;
    int     n_cmp = 0;
    int     n_err = 0;
    bit     mon_en = 1'b0;

    // reference model state: where the current packet goes and what has been counted
    phase_e phase = OUTSIDE;
    int     m_ports[$];
    bit     m_dropped = 1'b0;
    int     m_fwd = 0;
    int     m_drop = 0;
    bit     pend_v = 1'b0;
    bit     pend_flag = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        phase = OUTSIDE;
        m_ports.delete();
        m_dropped = 1'b0;
        m_fwd = 0;
        m_drop = 0;
    endtask

    task automatic emit(input logic [W-1:0] w);
        wexp_t e;
        e.cyc  = cyc + 1;
        e.data = w;
        foreach (m_ports[j]) wq[m_ports[j]].push_back(e);
    endtask

    task automatic model_valid(input bit flag);
        vexp_t e;
        e.cyc  = cyc + 1;
        e.flag = flag;
        if (!m_dropped) foreach (m_ports[j]) vq[m_ports[j]].push_back(e);
    endtask

    task automatic model_word(input logic [W-1:0] w, input logic [N-1:0] alf);
        logic [1:0] kind;
        int         p;
        int         targets[$];
        bit         blocked;
        kind = w[W-1:W-2];
        case (phase)
            OUTSIDE: begin
                if (kind == 2'b01) begin
                    p = int'(w[PORT_LSB +: 6]);
                    if (p < N) targets.push_back(p);
                    else if (p == 63) for (int k = 0; k < N; k++) targets.push_back(k);
                    blocked = (targets.size() == 0);
                    foreach (targets[j]) if (alf[targets[j]]) blocked = 1'b1;
                    if (blocked) begin
                        m_dropped = 1'b1;
                        m_drop++;
                        phase = DISCARDING;
                    end else begin
                        m_ports   = targets;
                        m_dropped = 1'b0;
                        emit(w);
                        phase = FORWARDING;
                    end
                end else if (kind == 2'b10) begin
                    m_drop++;
                end
            end
            FORWARDING: begin
                emit(w);
                if (kind == 2'b10 || kind == 2'b01) begin
                    m_fwd++;
                    phase = OUTSIDE;
                end
            end
            DISCARDING: if (kind == 2'b10) phase = OUTSIDE;
        endcase
    endtask

    function automatic logic [W-1:0] make_word(input logic [1:0] kind, input logic [5:0] port);
        logic [W-1:0] w;
        w = {kind, 4'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        if (kind == 2'b01) w[PORT_LSB +: 6] = port;
        return w;
    endfunction

    task automatic drive_word(input logic [W-1:0] w, input logic [N-1:0] alf,
                              input bit vwr, input bit vflag, input bit do_rst);
        @(posedge clk); #1;
        if (pend_v) begin
            vwr    = 1'b1;
            vflag  = pend_flag;
            pend_v = 1'b0;
        end
        rst             = do_rst;
        in_goe_data_wr  = 1'b1;
        in_goe_data     = w;
        in_port_alf     = alf;
        in_goe_valid_wr = vwr;
        in_goe_valid    = vflag;
        if (do_rst) begin
            model_reset();
        end else begin
            if (vwr) model_valid(vflag);
            model_word(w, alf);
        end
    endtask

    task automatic drive_idle(input bit vwr, input bit vflag);
        @(posedge clk); #1;
        if (pend_v) begin
            vwr    = 1'b1;
            vflag  = pend_flag;
            pend_v = 1'b0;
        end
        rst             = 1'b0;
        in_goe_data_wr  = 1'b0;
        in_goe_data     = make_word(2'b01, 6'($urandom));
        in_port_alf     = N'($urandom);
        in_goe_valid_wr = vwr;
        in_goe_valid    = vflag;
        if (vwr) model_valid(vflag);
    endtask

    // vmode: 0 strobe with tail, 1 strobe one cycle after tail, 2 strobe rides the next word
    task automatic send_pkt(input logic [5:0] port, input int len, input logic [N-1:0] head_alf,
                            input logic [N-1:0] mid_alf, input int vmode, input bit vflag,
                            input bit last_is_head, input int rst_idx);
        logic [1:0] kind;
        for (int k = 0; k < len; k++) begin
            if (k == 0)             kind = 2'b01;
            else if (k == len - 1)  kind = last_is_head ? 2'b01 : 2'b10;
            else                    kind = 2'b11;
            drive_word(make_word(kind, port), (k == 0) ? head_alf : mid_alf,
                       (k == len - 1) && (vmode == 0), vflag, k == rst_idx);
        end
        if (vmode == 1) begin
            drive_idle(1'b1, vflag);
        end else if (vmode == 2) begin
            pend_v    = 1'b1;
            pend_flag = vflag;
        end
    endtask

    task automatic check_counters(input string tag);
        drive_idle(1'b0, 1'b0);
        drive_idle(1'b0, 1'b0);
        check({tag, "_fwd_cnt"}, W'(fwd_pkt_cnt), W'(m_fwd));
        check({tag, "_drop_cnt"}, W'(drop_pkt_cnt), W'(m_drop));
    endtask

    always @(negedge clk) begin
        wexp_t we;
        vexp_t ve;
        bit    ew, ev;
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                ew = (wq[i].size() > 0) && (wq[i][0].cyc == cyc);
                check($sformatf("p%0d_data_wr", i), W'(pktout_data_wr[i]), W'(ew));
                if (ew) begin
                    we = wq[i].pop_front();
                    if (pktout_data_wr[i]) check($sformatf("p%0d_data", i), pktout_data[i*W +: W], we.data);
                end else if (!pktout_data_wr[i]) begin
                    check($sformatf("p%0d_idle_data", i), pktout_data[i*W +: W], '0);
                end
                ev = (vq[i].size() > 0) && (vq[i][0].cyc == cyc);
                check($sformatf("p%0d_valid_wr", i), W'(pktout_data_valid_wr[i]), W'(ev));
                if (ev) begin
                    ve = vq[i].pop_front();
                    if (pktout_data_valid_wr[i]) check($sformatf("p%0d_valid", i), W'(pktout_data_valid[i]), W'(ve.flag));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] port;
        int         sel, len, rst_idx, vmode;
        logic [N-1:0] half;

        rst = 1'b1;
        in_goe_data_wr  = 1'b0;
        in_goe_data     = '0;
        in_goe_valid_wr = 1'b0;
        in_goe_valid    = 1'b0;
        in_port_alf     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_wr", W'(pktout_data_wr), '0);
        check("rst_data", W'(pktout_data[W-1:0]) | pktout_data[3*W +: W], '0);
        check("rst_valid_wr", W'(pktout_data_valid_wr), '0);
        check("rst_valid", W'(pktout_data_valid), '0);
        check("rst_fwd_cnt", W'(fwd_pkt_cnt), '0);
        check("rst_drop_cnt", W'(drop_pkt_cnt), '0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // T1 unicast to port 2
        send_pkt(6'd2, 3, '0, '0, 1, 1'b1, 1'b0, -1);
        check_counters("t1");
        // T2 broadcast
        send_pkt(6'h3F, 3, '0, '0, 1, 1'b1, 1'b0, -1);
        check_counters("t2");
        // T3 out-of-range port
        send_pkt(6'd5, 3, '0, '0, 1, 1'b1, 1'b0, -1);
        check_counters("t3");
        // T4 backpressure at head drops; backpressure mid-packet does not truncate
        send_pkt(6'd1, 3, 4'b0010, '0, 1, 1'b1, 1'b0, -1);
        send_pkt(6'd1, 4, '0, 4'b0010, 1, 1'b0, 1'b0, -1);
        check_counters("t4");
        // T5 reset on word 2 of a 4-word packet
        send_pkt(6'd0, 4, '0, '0, 1, 1'b1, 1'b0, 1);
        check_counters("t5");
        // T6 back-to-back, valid strobe coincident with second head
        send_pkt(6'd0, 3, '0, '0, 2, 1'b1, 1'b0, -1);
        send_pkt(6'd3, 3, '0, '0, 0, 1'b0, 1'b0, -1);
        check_counters("t6");

        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3 || sel >= 8) port = 6'($urandom_range(0, N - 1));
            else if (sel <= 5)        port = 6'h3F;
            else if (sel == 6)        port = 6'd5;
            else                      port = 6'($urandom_range(N, 62));
            len     = $urandom_range(2, 6);
            half    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            vmode   = $urandom_range(0, 2);
            rst_idx = ($urandom_range(0, 29) == 0) ? $urandom_range(0, len - 1) : -1;
            send_pkt(port, len, half, N'($urandom), vmode, 1'($urandom),
                     $urandom_range(0, 19) == 0, rst_idx);
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 1) == 0) drive_word(make_word(2'b11, '0), '0, 1'b0, 1'b0, 1'b0);
                drive_word(make_word(2'b10, '0), '0, 1'b0, 1'b0, 1'b0);
            end
            repeat ($urandom_range(0, 2)) drive_idle(1'b0, 1'b0);
        end
        check_counters("rand");

        repeat (3) drive_idle(1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("p%0d_words_left", i), W'(wq[i].size()), '0);
            check($sformatf("p%0d_valids_left", i), W'(vq[i].size()), '0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
